// File: rtl/mem_hold_ctrl.sv
// Single-outstanding memory responder for the control unit's MR/MW requests.
// Holds the pipeline (HOLD) while an access is in flight and reports timeouts/illegal requests.
module mem_hold_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MR_IN,
    input  logic              MW_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] WDATA_IN,
    output logic              HOLD,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_VLD,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              DBG_STATE
);

    // Handshake: MEM_REQ rises with the latched access and stays up, with
    // MEM_WE/MEM_ADDR/MEM_WDATA stable, until the cycle after MEM_ACK is seen
    // high (or the timeout fires). MEM_ACK is ignored outside BUSY.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_hold;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_vld;
    logic              r_err;
    logic [7:0]        r_cnt;

    state_t            w_state_nxt;
    logic              w_hold_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_rdata_vld_nxt;
    logic              w_err_nxt;
    logic [7:0]        w_cnt_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_hold      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rdata_vld <= w_rdata_vld_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_rdata_vld_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (MR_IN && MW_IN) begin
                    w_err_nxt = 1'b1;
                end else if (MR_IN || MW_IN) begin
                    w_state_nxt     = S_BUSY;
                    w_hold_nxt      = 1'b1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = MW_IN;
                    w_mem_addr_nxt  = ADDR_IN;
                    w_mem_wdata_nxt = WDATA_IN;
                    w_cnt_nxt       = '0;
                end
            end
            S_BUSY: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (MEM_ACK) begin
                    w_state_nxt   = S_IDLE;
                    w_hold_nxt    = 1'b0;
                    w_mem_req_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_rdata_nxt     = MEM_RDATA;
                        w_rdata_vld_nxt = 1'b1;
                    end
                end else if (r_cnt >= LP_CNT_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_hold_nxt    = 1'b0;
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_hold_nxt    = 1'b0;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign HOLD      = r_hold;
    assign RDATA     = r_rdata;
    assign RDATA_VLD = r_rdata_vld;
    assign ERR       = r_err;
    assign MEM_REQ   = r_mem_req;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign DBG_STATE = r_state;

endmodule
